// File: rtl/bcd_stopwatch.sv
// Two-digit BCD up/down stopwatch feeding the seven-segment display mux.
// Optional button debouncing is enabled by defining STOPWATCH_DEBOUNCE_EN.
module bcd_stopwatch #(
  parameter int TICK_DIV        = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       up_down,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       wrap_pulse,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam int             PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("bcd_stopwatch: TICK_DIV must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("bcd_stopwatch: DEBOUNCE_CYCLES must be >= 1");
  end

  // Synchronizer bit map: [0] start_stop, [1] clear, [2] up_down, [3] load, [11:4] load_val
  logic [11:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]  btn_sync, btn_lvl, btn_prev_q, btn_prev_d, btn_edge;
  logic        ud_s, load_s, ss_edge, clr_edge;
  logic [7:0]  load_val_s;

  assign btn_sync   = sync2_q[1:0];
  assign ud_s       = sync2_q[2];
  assign load_s     = sync2_q[3];
  assign load_val_s = sync2_q[11:4];

  always_comb begin
    sync1_d    = {load_val, load, up_down, clear, start_stop};
    sync2_d    = sync1_q;
    btn_prev_d = btn_lvl;
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]         db_lvl_q, db_lvl_d;

  // Filtered level flips only after DEBOUNCE_CYCLES samples that all disagree with it.
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    for (int i = 0; i < 2; i++) begin
      if (btn_sync[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl_d[i] = btn_sync[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q <= '0;
      db_lvl_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign btn_lvl = db_lvl_q;
`else
  assign btn_lvl = btn_sync;
`endif

  assign btn_edge = btn_lvl & ~btn_prev_q;
  assign ss_edge  = btn_edge[0];
  assign clr_edge = btn_edge[1];

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic          running_q, running_d, wrap_q, wrap_d;
  logic          tick, load_ok;

  assign tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
  assign load_ok = load_s && (state_q != ST_RUN) &&
                   (load_val_s[7:4] <= 4'd9) && (load_val_s[3:0] <= 4'd9);

  // Priority: clear, then a valid load, then the tick/start_stop pair.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    wrap_d  = 1'b0;
    if (clr_edge) begin
      state_d = ST_IDLE;
      presc_d = '0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else if (load_ok) begin
      state_d = ST_PAUSE;
      presc_d = '0;
      tens_d  = load_val_s[7:4];
      ones_d  = load_val_s[3:0];
    end else begin
      if (state_q == ST_RUN) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (ud_s) begin
            if (ones_q != 4'd9) begin
              ones_d = ones_q + 4'd1;
            end else begin
              ones_d = 4'd0;
              if (tens_q != 4'd9) begin
                tens_d = tens_q + 4'd1;
              end else begin
                tens_d = 4'd0;
                wrap_d = 1'b1;
              end
            end
          end else begin
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              if (tens_q != 4'd0) begin
                tens_d = tens_q - 4'd1;
              end else begin
                tens_d = 4'd9;
                wrap_d = 1'b1;
              end
            end
          end
        end
      end
      if (ss_edge) begin
        case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: state_d = ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      btn_prev_q <= '0;
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  assign tens       = tens_q;
  assign ones       = ones_q;
  assign running    = running_q;
  assign wrap_pulse = wrap_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch (default build): directed scenarios plus random
// button/load traffic, all cycles checked against an integer-count model.
module tb_bcd_stopwatch;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop = 1'b0, clear = 1'b0, up_down = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] tens, ones;
  logic       running, wrap_pulse;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int wrap_seen = 0;

  bcd_stopwatch #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .up_down(up_down), .load(load), .load_val(load_val),
    .tens(tens), .ones(ones), .running(running), .wrap_pulse(wrap_pulse),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Inputs are seen two edges late; edges compare the two oldest samples.
  logic [11:0] h1, h2, h3;
  logic [9:0]  exp_q[$];
  logic [9:0]  exp_e;
  int  m_mode, m_val, m_phase;
  bit  m_wrap;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_mode = M_IDLE; m_val = 0; m_phase = 0; m_wrap = 0;
      exp_q.delete();
    end else begin
      logic       ss_e, clr_e, ud, ld;
      logic [7:0] lv;
      ss_e  = h2[0] & ~h3[0];
      clr_e = h2[1] & ~h3[1];
      ud    = h2[2];
      ld    = h2[3];
      lv    = h2[11:4];
      m_wrap = 0;
      if (clr_e) begin
        m_mode = M_IDLE; m_val = 0; m_phase = 0;
      end else if (ld && m_mode != M_RUN && lv[7:4] < 10 && lv[3:0] < 10) begin
        m_mode = M_PAUSE; m_val = lv[7:4] * 10 + lv[3:0]; m_phase = 0;
      end else begin
        if (m_mode == M_RUN) begin
          m_phase++;
          if (m_phase == TICK_DIV) begin
            m_phase = 0;
            if (ud) begin
              m_wrap = (m_val == 99);
              m_val  = (m_val + 1) % 100;
            end else begin
              m_wrap = (m_val == 0);
              m_val  = (m_val + 99) % 100;
            end
          end
        end
        if (ss_e) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
      end
      h3 = h2; h2 = h1;
      h1 = {load_val, load, up_down, clear, start_stop};
      exp_q.push_back({4'(m_val / 10), 4'(m_val % 10), (m_mode == M_RUN), m_wrap});
    end
  end

  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      check_eq("model_tens", 32'(tens), 32'(exp_e[9:6]));
      check_eq("model_ones", 32'(ones), 32'(exp_e[5:2]));
      check_eq("model_running", 32'(running), 32'(exp_e[1]));
      check_eq("model_wrap", 32'(wrap_pulse), 32'(exp_e[0]));
      if (wrap_pulse) wrap_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk) start_stop = 1'b1;
    @(negedge clk) start_stop = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    load_val = v;
    load     = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_running(input logic level, input string tag);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (running === level) found = 1;
    end
    check_eq(tag, 32'(running), 32'(level));
  endtask

  task automatic check_count(input string tag, input logic [7:0] bcd);
    check_eq(tag, 32'({tens, ones}), 32'(bcd));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state held while idle
    repeat (10) @(negedge clk);
    check_count("t1_count", 8'h00);
    check_eq("t1_running", 32'(running), 0);
    check_eq("t1_wrap", 32'(wrap_pulse), 0);

    // Count up 10 ticks
    w0 = wrap_seen;
    up_down = 1'b1;
    pulse_start();
    wait_running(1'b1, "t2_run_rise");
    repeat (40) @(negedge clk);
    check_count("t2_count", 8'h10);
    check_eq("t2_running", 32'(running), 1);
    check_eq("t2_no_wrap", 32'(wrap_seen - w0), 0);

    // Pause, preload 98, run across the up wrap
    pulse_start();
    wait_running(1'b0, "t3_pause");
    do_load(8'h98);
    check_count("t3_load", 8'h98);
    check_eq("t3_running", 32'(running), 0);
    pulse_start();
    wait_running(1'b1, "t3_run");
    repeat (4) @(negedge clk);
    check_count("t3_99", 8'h99);
    check_eq("t3_no_wrap_yet", 32'(wrap_pulse), 0);
    repeat (4) @(negedge clk);
    check_count("t3_00", 8'h00);
    check_eq("t3_wrap", 32'(wrap_pulse), 1);
    @(negedge clk);
    check_eq("t3_wrap_one_cycle", 32'(wrap_pulse), 0);

    // Down wrap from 00
    pulse_start();
    wait_running(1'b0, "t4_pause");
    up_down = 1'b0;
    do_load(8'h00);
    check_count("t4_load", 8'h00);
    pulse_start();
    wait_running(1'b1, "t4_run");
    repeat (4) @(negedge clk);
    check_count("t4_99", 8'h99);
    check_eq("t4_wrap", 32'(wrap_pulse), 1);
    @(negedge clk);
    check_eq("t4_wrap_one_cycle", 32'(wrap_pulse), 0);
    repeat (3) @(negedge clk);
    check_count("t4_98", 8'h98);

    // Invalid BCD and load during RUN are ignored
    pulse_start();
    wait_running(1'b0, "t5_pause");
    do_load(8'h42);
    check_count("t5_load", 8'h42);
    do_load(8'h3A);
    check_count("t5_bad_bcd", 8'h42);
    check_eq("t5_still_paused", 32'(running), 0);
    up_down = 1'b1;
    pulse_start();
    wait_running(1'b1, "t5_run");
    do_load(8'h3A);
    do_load(8'h11);
    check_eq("t5_run_load_ignored", 32'(running), 1);

    // Clear and start_stop together at 57: clear wins
    pulse_start();
    wait_running(1'b0, "t6_pause");
    do_load(8'h57);
    pulse_start();
    wait_running(1'b1, "t6_run");
    clear = 1'b1; start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0; start_stop = 1'b0;
    @(negedge clk);
    check_count("t6_at57", 8'h57);
    @(negedge clk);
    check_count("t6_clear_count", 8'h00);
    check_eq("t6_clear_idle", 32'(running), 0);
    check_eq("t6_clear_no_wrap", 32'(wrap_pulse), 0);

    // Async reset between edges
    pulse_start();
    wait_running(1'b1, "t6_restart");
    repeat (6) @(negedge clk);
    check_count("t6_pre_reset", 8'h01);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_count("t6_async_count", 8'h00);
    check_eq("t6_async_running", 32'(running), 0);
    check_eq("t6_async_wrap", 32'(wrap_pulse), 0);
    @(negedge clk);
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      start_stop = ($urandom_range(0, 15) == 0);
      clear      = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 31) == 0) up_down = ~up_down;
      load = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 1) == 1)
        load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        load_val = 8'($urandom_range(0, 255));
    end
    start_stop = 1'b0; clear = 1'b0; load = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
Upstream producer for the two-digit multiplexed seven-segment display stage. It generates the `tens`/`ones` BCD digit pair that the display stage currently takes as constants.
- Counts 00–99 at a prescaled tick rate, up or down.
- Start/stop and clear buttons, plus a BCD preload from switches.
- Digits are registered so the display mux samples stable values.

Parameters:
TICK_DIV, 10_000_000, clk cycles per count tick (>=2); benches use 4
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required when DEBOUNCE_EN is defined (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start_stop  input  1  button; each rising edge toggles run/pause
clear  input  1  button; rising edge returns to IDLE with count 00
up_down  input  1  level; 1 = count up, 0 = count down
load  input  1  level; load load_val when stopped
load_val  input  8  BCD preload, [7:4] tens, [3:0] ones
tens  output  4  BCD tens digit
ones  output  4  BCD ones digit
running  output  1  high while state is RUN
wrap_pulse  output  1  one-cycle pulse on 99->00 (up) or 00->99 (down)

Behaviour:
- Reset: reset is asynchronous and active-high; clock is clk. It takes effect immediately, with no clock edge needed, including mid-count.
- Reset values: tens=0, ones=0, running=0, wrap_pulse=0, state IDLE, prescaler 0, all synchronizers 0.
- Input synchronization: start_stop, clear, up_down, load and load_val each pass through a 2-FF synchronizer.
- Edge detection: start_stop and clear use a rising-edge detector (sync2 & ~prev).
- Input latency: an input first sampled high on edge N takes effect on the registered state/outputs at edge N+2.
- States:
  - IDLE: stopped, count 00, prescaler held at 0.
  - RUN: prescaler runs, count advances on tick.
  - PAUSE: stopped, count and prescaler retained.
- Transitions:
  - start_stop edge: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - clear edge, from any state: ->IDLE, count 00, prescaler 0.
  - load in IDLE or PAUSE with valid BCD (each nibble <=9): count=load_val, prescaler 0, state PAUSE.
  - Invalid BCD, or load while in RUN: ignored, no state or count change.
- Priority within one cycle: clear > load > start_stop.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN only.
  - tick is asserted internally in the cycle the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
  - First tick after IDLE->RUN arrives TICK_DIV cycles after entering RUN.
- Count on tick, up:
  - ones 0..8 -> +1.
  - ones 9 -> ones 0, tens +1.
  - 99 -> 00 with wrap_pulse=1 for exactly one cycle.
- Count on tick, down:
  - ones 1..9 -> -1.
  - ones 0 -> ones 9, tens -1.
  - 00 -> 99 with wrap_pulse.
- Direction: up_down sampled (synchronized) at the tick cycle; changing it mid-run affects the next tick only.
- tens and ones are never outside 0–9.
- Tick coinciding with a start_stop edge in RUN: the count advances, then the state becomes PAUSE.
- Tick coinciding with clear: clear wins; no wrap_pulse.
- Output timing: tens/ones/running/wrap_pulse are registered and update one edge after the internal decision; no combinational input-to-output path.

Optional Feature:
Macro STOPWATCH_DEBOUNCE_EN.
- Defined:
  - start_stop and clear each pass a debouncer after synchronization.
  - The filtered level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
  - The edge detector operates on the filtered level.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
  - Latency grows by DEBOUNCE_CYCLES cycles.
  - Debouncer counters reset to 0, filtered level 0.
- Undefined: edges are taken directly from the synchronizer outputs; no debounce logic is instantiated.

Test Plan:
1. Assert reset, release, idle 10 cycles -> tens=0, ones=0, running=0, wrap_pulse=0 throughout.
2. TICK_DIV=4, up_down=1, pulse start_stop one cycle, wait 40 cycles after running rises -> tens=1, ones=0; running=1; no wrap_pulse.
3. Pulse start_stop again to PAUSE, then load_val=8'h98, load=1 for 3 cycles, then start_stop -> count 98->99, then 00 with wrap_pulse high exactly 1 cycle, 4 cycles apart.
4. Count 00 in PAUSE, up_down=0, start_stop, one tick -> tens=9, ones=9, wrap_pulse one cycle; next tick -> 98.
5. In PAUSE at 42, load_val=8'h3A, load=1 -> count stays 42; load_val=8'h3A while RUN -> ignored.
6. In RUN at 57:
   - Raise clear and start_stop on the same edge -> IDLE, 00, running=0.
   - Restart, then assert async reset between clock edges -> all outputs 0 before the next clk edge.
